split_n: RTL and testbench
==========================

# split_n

N-way clocked fork for four-phase (return-to-zero) req/ack channels with a data bundle. One input token is broadcast to every enabled output branch. The input is acknowledged only once every enabled branch has consumed the token. It generalises the two-way C-element split to N branches, a data payload, a static branch mask, and an eager mode in which branches complete their handshakes independently. It sits between a clocked producer and several clocked consumers. All handshake inputs are synchronous to `clk`; any synchronisers live outside this block.

## Interface
- `N`, 2: number of output branches (≥1).
- `W`, 8: data width (≥1).
- `EAGER`, 1'b0: 0 = lazy (all branches held in lock-step, C-element behaviour); 1 = eager (each branch runs its own full four-phase cycle).
- `MASK`, {N{1'b1}}: static branch enable. A 0 bit means the branch never requests and counts as permanently done.

- `clk`  in  1  clock; rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `r_i`  in  1  input request.
- `a_i`  out  1  input acknowledge.
- `d_i`  in  W  input data, valid while `r_i`=1.
- `r_o`  out  N  per-branch request.
- `a_o`  in  N  per-branch acknowledge.
- `d_o`  out  W  broadcast data, shared by all branches.

## Operation
- Enabled set E = MASK. `all_ack` = (a_o & MASK) == MASK. `all_low` = (a_o & MASK) == 0.
- States: IDLE, FWD, ACK, RTZ. RTZ is used in lazy mode only.
- **IDLE**
  - `a_i`=0, `r_o`=0.
  - On `r_i`=1: capture `d_o`←`d_i`, set `r_o`←MASK, go to FWD.
  - If MASK==0, go straight to ACK instead; `r_o` stays 0.
- **Lazy FWD**: on `all_ack`, set `a_i`←1 and go to ACK. `r_o` stays asserted.
- **Lazy ACK**: on `r_i`=0, set `r_o`←0 and go to RTZ. `a_i` stays 1.
- **Lazy RTZ**: on `all_low`, set `a_i`←0 and go to IDLE.
- **Eager FWD**: each enabled branch k runs its own tracker.
  - `r_o[k]`=1 until `a_o[k]`=1 is sampled, then `r_o[k]`←0.
  - Once `a_o[k]`=0 is sampled after that, `done[k]`←1.
  - When `done | ~MASK` is all ones: set `a_i`←1, clear `done`, go to ACK.
- **Eager ACK**: on `r_i`=0, set `a_i`←0 and go to IDLE.
- `d_o` changes only on capture in IDLE and is held otherwise.
- Protocol violations are ignored and state is held. This covers:
  - `a_o[k]` rising while `r_o[k]`=0;
  - `r_i` falling before `a_i` rises;
  - any activity on a masked `a_o` bit.
- Reset, asynchronous and mid-cycle included: state←IDLE, `a_i`←0, `r_o`←0, `d_o`←0, `done`←0.

## Timing
- All outputs are registered and reflect inputs sampled at the preceding rising edge.
- Lazy mode, full token (one cycle per condition):
  - `r_i`=1 sampled at edge t → `r_o`=MASK after t.
  - `all_ack` at edge u → `a_i`=1 after u.
  - `r_i`=0 at edge v → `r_o`=0 after v.
  - `all_low` at edge w → `a_i`=0 after w.
  - Next capture is possible at edge w+1 at the earliest.
- Eager mode, per branch:
  - `a_o[k]`=1 at edge u → `r_o[k]`=0 after u.
  - `a_o[k]`=0 at edge v → `done[k]` after v.
  - The last `done` is set at edge x → `a_i`=1 after x+1. This is the state-update cycle.
- Minimum per-token period with zero-latency consumers: lazy 4 cycles, eager 5 cycles.
- MASK==0: `a_i` mirrors `r_i`, one cycle late on each edge; `d_o` still captures.

## Structure
- Package `split_pkg`:
  - `split_state_e` enum {IDLE, FWD, ACK, RTZ}, 2 bits;
  - localparams for the reset values.
- Sub-module `split_branch`: the per-branch eager tracker (`r_o[k]`, `done[k]`), instantiated N times in a generate loop when EAGER=1. In lazy mode it is bypassed and `r_o` is driven directly from the FSM.

## Test plan
- Lazy, N=3, W=8, MASK=3'b111: `r_i`↑ with `d_i`=8'hA5; acks rise at cycles 2, 4, 6 → `r_o`=3'b111 until `r_i`↓, `a_i`↑ only after cycle 6, `d_o`=8'hA5. Acks fall staggered → `a_i`↓ only after the last one.
- Eager, N=3: branch 0 acks within 1 cycle, branch 2 within 5 cycles → `r_o[0]` completes a full cycle while `r_o[2]` is still 1; `a_i`↑ exactly 1 cycle after `done[2]`.
- MASK=3'b101, N=3: toggling `a_o[1]` randomly → `r_o[1]` stays 0 and has no effect; token completes on branches 0 and 2 only.
- MASK=0: 4 back-to-back tokens → `a_i` follows `r_i` with 1-cycle lag; `r_o` stays 0; `d_o` tracks each captured `d_i`.
- `rst` pulse asserted mid-FWD, between clock edges → `r_o`, `a_i`, `d_o` go to 0 immediately. After release, a new token completes normally.
- Violation: `a_o[0]`↑ while in IDLE, and `r_i`↓ during FWD → no state change and no spurious `a_i`; a subsequent legal token completes.

Source files
------------

// File: rtl/split_pkg.sv
// Shared types and reset values for the N-way four-phase fork.
package split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACK  = 2'd2,
        RTZ  = 2'd3
    } split_state_e;

    // Per-branch eager tracker: request out, wait for ack low, then report done.
    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_REQ  = 2'd1,
        BR_LOW  = 2'd2,
        BR_DONE = 2'd3
    } split_branch_e;

    localparam split_state_e  RST_STATE    = IDLE;
    localparam split_branch_e RST_BR_STATE = BR_IDLE;
    localparam logic          RST_ACK      = 1'b0;
    localparam logic          RST_REQ      = 1'b0;
    localparam logic          RST_DONE     = 1'b0;

endpackage

// File: rtl/split_branch.sv
// Eager-mode branch tracker: runs one full four-phase cycle per token and
// holds done until the fork retires the token.
module split_branch
    import split_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic retire,
    input  logic ack,
    output logic req,
    output logic done
);

    split_branch_e state, state_nx;
    logic          req_nx;
    logic          done_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_BR_STATE;
            req   <= RST_REQ;
            done  <= RST_DONE;
        end else begin
            state <= state_nx;
            req   <= req_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = req;
        done_nx  = done;
        case (state)
            BR_IDLE: if (go) begin
                state_nx = BR_REQ;
                req_nx   = 1'b1;
            end
            BR_REQ: if (ack) begin
                state_nx = BR_LOW;
                req_nx   = 1'b0;
            end
            BR_LOW: if (!ack) begin
                state_nx = BR_DONE;
                done_nx  = 1'b1;
            end
            BR_DONE: if (retire) begin
                state_nx = BR_IDLE;
                done_nx  = 1'b0;
            end
            default: state_nx = BR_IDLE;
        endcase
    end

endmodule

// File: rtl/split_n.sv
// N-way clocked fork for four-phase req/ack channels: one input token is
// broadcast to every enabled branch, lazy (lock-step) or eager (per branch).
module split_n
    import split_pkg::*;
#(
    parameter int unsigned    N     = 2,
    parameter int unsigned    W     = 8,
    parameter bit             EAGER = 1'b0,
    parameter logic [N-1:0]   MASK  = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r_i,
    output logic         a_i,
    input  logic [W-1:0] d_i,
    output logic [N-1:0] r_o,
    input  logic [N-1:0] a_o,
    output logic [W-1:0] d_o
);

    split_state_e state, state_nx;
    logic         a_i_nx;
    logic [W-1:0] d_o_nx;
    logic         go;
    logic         retire;
    logic [N-1:0] done;
    logic         all_ack;
    logic         all_low;
    logic         all_done;

    // Masked acks are ignored entirely; masked branches count as done.
    assign all_ack  = (a_o & MASK) == MASK;
    assign all_low  = (a_o & MASK) == '0;
    assign all_done = &(done | ~MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            a_i   <= RST_ACK;
            d_o   <= '0;
        end else begin
            state <= state_nx;
            a_i   <= a_i_nx;
            d_o   <= d_o_nx;
        end
    end

    // retire drops lazy requests on ACK->RTZ and clears eager done bits on FWD->ACK.
    always_comb begin
        state_nx = state;
        a_i_nx   = a_i;
        d_o_nx   = d_o;
        go       = 1'b0;
        retire   = 1'b0;
        case (state)
            IDLE: if (r_i) begin
                d_o_nx = d_i;
                if (MASK == '0) begin
                    state_nx = ACK;
                    a_i_nx   = 1'b1;
                end else begin
                    state_nx = FWD;
                    go       = 1'b1;
                end
            end
            FWD: if (EAGER ? all_done : all_ack) begin
                state_nx = ACK;
                a_i_nx   = 1'b1;
                retire   = EAGER;
            end
            ACK: if (!r_i) begin
                if (EAGER || (MASK == '0)) begin
                    state_nx = IDLE;
                    a_i_nx   = 1'b0;
                end else begin
                    state_nx = RTZ;
                    retire   = 1'b1;
                end
            end
            RTZ: if (all_low) begin
                state_nx = IDLE;
                a_i_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    generate
        if (EAGER) begin : g_eager
            for (genvar k = 0; k < int'(N); k++) begin : g_br
                split_branch u_br (
                    .clk    (clk),
                    .rst    (rst),
                    .go     (go & MASK[k]),
                    .retire (retire),
                    .ack    (a_o[k]),
                    .req    (r_o[k]),
                    .done   (done[k])
                );
            end
        end else begin : g_lazy
            logic [N-1:0] req_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)         req_q <= {N{RST_REQ}};
                else if (go)     req_q <= MASK;
                else if (retire) req_q <= '0;
            end

            assign r_o  = req_q;
            assign done = '0;
        end
    endgenerate

endmodule

// File: tb/tb_split_n.sv
// Scoreboarded random bench for split_n over lazy/eager and several branch masks.
module tb_split_n;

    localparam int NI = 5;
    localparam logic [2:0] MSK [NI] = '{3'b111, 3'b111, 3'b101, 3'b000, 3'b101};
    localparam bit         EGR [NI] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1};

    logic       clk;
    logic       rst;
    logic       r_i [NI];
    logic       a_i [NI];
    logic [7:0] d_i [NI];
    logic [2:0] r_o [NI];
    logic [2:0] a_o [NI];
    logic [7:0] d_o [NI];

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];
    logic [15:0] sb_item;
    logic        prev_ai [NI];

    split_n #(.N(3), .W(8), .EAGER(1'b0), .MASK(3'b111)) u_lazy (
        .clk(clk), .rst(rst), .r_i(r_i[0]), .a_i(a_i[0]), .d_i(d_i[0]),
        .r_o(r_o[0]), .a_o(a_o[0]), .d_o(d_o[0]));
    split_n #(.N(3), .W(8), .EAGER(1'b1), .MASK(3'b111)) u_eager (
        .clk(clk), .rst(rst), .r_i(r_i[1]), .a_i(a_i[1]), .d_i(d_i[1]),
        .r_o(r_o[1]), .a_o(a_o[1]), .d_o(d_o[1]));
    split_n #(.N(3), .W(8), .EAGER(1'b0), .MASK(3'b101)) u_lazy_m (
        .clk(clk), .rst(rst), .r_i(r_i[2]), .a_i(a_i[2]), .d_i(d_i[2]),
        .r_o(r_o[2]), .a_o(a_o[2]), .d_o(d_o[2]));
    split_n #(.N(3), .W(8), .EAGER(1'b0), .MASK(3'b000)) u_lazy_z (
        .clk(clk), .rst(rst), .r_i(r_i[3]), .a_i(a_i[3]), .d_i(d_i[3]),
        .r_o(r_o[3]), .a_o(a_o[3]), .d_o(d_o[3]));
    split_n #(.N(3), .W(8), .EAGER(1'b1), .MASK(3'b101)) u_eager_m (
        .clk(clk), .rst(rst), .r_i(r_i[4]), .a_i(a_i[4]), .d_i(d_i[4]),
        .r_o(r_o[4]), .a_o(a_o[4]), .d_o(d_o[4]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Every rising a_i must retire the oldest issued token on the same instance.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (a_i[i] === 1'b1 && prev_ai[i] !== 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_ack inst%0d got d_o=%0h exp=no ack t=%0t", i, d_o[i], $time);
                end else begin
                    sb_item = sb.pop_front();
                    chk("sb_inst", i, 32'(i), 32'(sb_item[15:8]));
                    chk("sb_data", i, 32'(d_o[i]), 32'(sb_item[7:0]));
                end
            end
            prev_ai[i] = a_i[i];
        end
    end

    // One token with consumer delays chosen up front; expected edges derive from them.
    // Called just after a rising edge; returns just after the edge that ends the token.
    task automatic token(input int i, input logic [7:0] d, input bit dir, input bit viol);
        int r [3];
        int f [3];
        int u, v, w, mr, mf;
        logic [2:0] m;
        logic [2:0] er;
        bit eg;
        m  = MSK[i];
        eg = EGR[i];
        mr = 0;
        mf = 0;
        for (int k = 0; k < 3; k++) begin
            r[k] = 0;
            f[k] = 0;
            if (m[k]) begin
                if (dir)       r[k] = eg ? 2*k + 1 : 2*k + 2;
                else if (viol) r[k] = int'($urandom_range(5, 3));
                else           r[k] = int'($urandom_range(4, 1));
                if (r[k] > mr) mr = r[k];
            end
        end
        if (!eg) begin
            u  = mr + 1;
            v  = u + 1;
            mf = v - 1;
            for (int k = 0; k < 3; k++) if (m[k]) begin
                f[k] = dir ? v + 2*k : v + int'($urandom_range(3, 0));
                if (f[k] > mf) mf = f[k];
            end
            w = mf + 1;
        end else begin
            for (int k = 0; k < 3; k++) if (m[k]) begin
                f[k] = dir ? r[k] + 1 + k : r[k] + 1 + int'($urandom_range(3, 0));
                if (f[k] > mf) mf = f[k];
            end
            u = mf + 2;
            v = 0;
            w = u + 1;
        end
        sb.push_back({8'(i), d});
        r_i[i] = 1'b1;
        d_i[i] = d;
        for (int e = 1; e <= w; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                er[k] = eg ? (m[k] && e <= r[k]) : (m[k] && e < v);
            chk("a_i", i, 32'(a_i[i]), 32'(e >= u && e < w));
            chk("r_o", i, 32'(r_o[i]), 32'(er));
            chk("d_o", i, 32'(d_o[i]), 32'(d));
            for (int k = 0; k < 3; k++)
                a_o[i][k] = m[k] ? (e >= r[k] && e < f[k]) : 1'($urandom);
            r_i[i] = (e < u) && !(viol && (e == 1 || e == 2));
            d_i[i] = (e < u) ? d : 8'($urandom);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            r_i[i] = 1'b0;
            d_i[i] = 8'h00;
            a_o[i] = 3'b000;
        end
        #12;
        for (int i = 0; i < NI; i++) begin
            chk("rst_a_i", i, 32'(a_i[i]), 32'd0);
            chk("rst_r_o", i, 32'(r_o[i]), 32'd0);
            chk("rst_d_o", i, 32'(d_o[i]), 32'd0);
        end
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        token(0, 8'hA5, 1'b1, 1'b0);
        token(1, 8'h5A, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++)
            for (int i = 0; i < NI; i++)
                token(i, 8'($urandom), 1'b0, 1'b0);
        for (int n = 0; n < 4; n++)
            token(3, 8'($urandom), 1'b0, 1'b0);

        // Asynchronous reset in the middle of a lazy FWD phase.
        r_i[0] = 1'b1;
        d_i[0] = 8'h3C;
        @(posedge clk);
        #1;
        chk("pre_rst_r_o", 0, 32'(r_o[0]), 32'h7);
        chk("pre_rst_d_o", 0, 32'(d_o[0]), 32'h3C);
        #2 rst = 1'b1;
        #1;
        chk("async_r_o", 0, 32'(r_o[0]), 32'd0);
        chk("async_a_i", 0, 32'(a_i[0]), 32'd0);
        chk("async_d_o", 0, 32'(d_o[0]), 32'd0);
        rst = 1'b0;
        r_i[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_r_o", 0, 32'(r_o[0]), 32'd0);
        token(0, 8'hC3, 1'b0, 1'b0);
        token(1, 8'h96, 1'b0, 1'b0);

        // Acks without a request, then r_i dropped early during FWD.
        for (int i = 0; i < 2; i++) begin
            a_o[i] = 3'b001;
            for (int e = 0; e < 3; e++) begin
                @(posedge clk);
                #1;
                chk("idle_viol_r_o", i, 32'(r_o[i]), 32'd0);
                chk("idle_viol_a_i", i, 32'(a_i[i]), 32'd0);
            end
            a_o[i] = 3'b000;
            token(i, 8'($urandom), 1'b0, 1'b1);
            token(i, 8'($urandom), 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
